mont_convert: RTL and testbench
===============================

MONT_CONVERT -- requirements
Module: mont_convert

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; R = 2^WIDTH.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port value_in, input, WIDTH bits: operand, normal domain for encode, Montgomery domain for decode.
REQ-005 The block SHALL have port modulo_in, input, WIDTH bits: modulus n, odd, 3 <= n.
REQ-006 The block SHALL have port mode_in, input, 1 bit: 0 = encode (x*R mod n), 1 = decode (x*R^-1 mod n).
REQ-007 The block SHALL have port valid_in, input, 1 bit: start request, sampled only in IDLE.
REQ-008 The block SHALL have port value_out, output, WIDTH bits: converted result.
REQ-009 The block SHALL have port r_mod_out, output, WIDTH bits: R mod n, valid with an encode result, 0 for decode.
REQ-010 The block SHALL have port valid_out, output, 1 bit: one-cycle result strobe.
REQ-011 The block SHALL have port error_out, output, 1 bit: qualifies valid_out; the operand was rejected.
REQ-012 The block SHALL have port busy_out, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL use FSM states IDLE, RUN, FINAL, DONE.
REQ-014 In IDLE with valid_in=1 at edge k, the block SHALL latch value_in, modulo_in and mode_in, and clear the iteration counter.
REQ-015 At edge k, the block SHALL go to DONE with error_out=1 and value_out=0 if modulo_in is even, modulo_in < 3, or value_in >= modulo_in; otherwise it goes to RUN.
REQ-016 Encode SHALL use a WIDTH+1-bit accumulator a=value and r=1; for each of WIDTH RUN cycles, a=2a and r=2r, each reduced by subtracting n once if >= n.
REQ-017 Decode SHALL use a WIDTH+1-bit accumulator a=value; for each of WIDTH RUN cycles, if a is odd then a=a+n, then a=a>>1.
REQ-018 RUN SHALL last exactly WIDTH cycles (edges k+1..k+WIDTH), then go to FINAL.
REQ-019 FINAL (edge k+WIDTH+1) SHALL subtract n once if a >= n and register value_out, plus r_mod_out for encode.
REQ-020 valid_out SHALL be high for exactly one cycle, in DONE, which returns to IDLE on the next edge.
REQ-021 Normal latency SHALL be valid_out high in the cycle after edge k+WIDTH+1; error latency SHALL be valid_out high in the cycle after edge k.
REQ-022 valid_in while busy_out=1 SHALL be ignored; input changes during RUN SHALL NOT affect the result.
REQ-023 value_out and r_mod_out SHALL hold their last values until the next DONE.
REQ-024 valid_in asserted in the DONE cycle SHALL be ignored; a new request is accepted only from IDLE.
REQ-025 All intermediate values SHALL stay below 2n, so a single compare-subtract per step is sufficient.

Reset
REQ-026 Asserting rst_in (low) at any time, including mid-RUN, SHALL immediately force IDLE and clear value_out, r_mod_out, valid_out, error_out, busy_out and the counter to 0.
REQ-027 After rst_in deasserts, the first valid_in in IDLE SHALL start a fresh operation with no residue from an aborted one.

Structure
REQ-028 Package mont_pkg SHALL hold the FSM state enum and mode constants MODE_ENCODE=0 and MODE_DECODE=1; it is shared with mod_exponent users.
REQ-029 The block SHALL contain one sub-module, mont_bit_step: a combinational single-iteration datapath (double-reduce or conditional-add-halve) selected by mode, instantiated twice (a path, r path).
REQ-030 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=16, n=61)
REQ-031 Encode 8 -> value_out=54, r_mod_out=22, valid_out one cycle after edge k+17, error_out=0.
REQ-032 Decode 54 -> value_out=8; decode 22 -> value_out=1; r_mod_out=0.
REQ-033 modulo 60, or value 69 with n=61 -> valid_out and error_out high one cycle after edge k, value_out=0, busy_out low afterwards.
REQ-034 Second valid_in (decode 22) asserted 5 cycles after an encode-8 start -> ignored, single result 54, no second valid_out.
REQ-035 rst_in pulsed low 8 cycles into encode 8 -> all outputs 0 immediately; a subsequent decode 54 returns 8 with normal latency.
REQ-036 Random odd n in [3, 65535], random x < n: decode(encode(x)) == x, and encode(1) == r_mod_out == 65536 mod n.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery domain converter and mod_exponent users.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL,
    DONE
  } mont_state_t;

  localparam logic MODE_ENCODE = 1'b0;
  localparam logic MODE_DECODE = 1'b1;

endpackage

// File: rtl/mont_convert_if.sv
// Request/result bundle of mont_convert; the slave side is the converter.
interface mont_convert_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] modulo_in;
  logic             mode_in;
  logic             valid_in;
  logic [WIDTH-1:0] value_out;
  logic [WIDTH-1:0] r_mod_out;
  logic             valid_out;
  logic             error_out;
  logic             busy_out;

  modport slave (
    input  value_in, modulo_in, mode_in, valid_in,
    output value_out, r_mod_out, valid_out, error_out, busy_out
  );

  modport master (
    output value_in, modulo_in, mode_in, valid_in,
    input  value_out, r_mod_out, valid_out, error_out, busy_out
  );
endinterface

// File: rtl/mont_bit_step.sv
// One conversion iteration: double-and-reduce (encode) or conditional add-n then halve (decode).
module mont_bit_step
  import mont_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             mode,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] modulo,
  output logic [WIDTH:0]   result
);

  logic [WIDTH+1:0] wide_n;
  logic [WIDTH+1:0] dbl;
  logic [WIDTH+1:0] sum;

  always_comb begin
    wide_n = (WIDTH+2)'(modulo);
    dbl    = {acc, 1'b0};
    sum    = (WIDTH+2)'(acc) + wide_n;
    result = '0;
    if (mode == MODE_ENCODE) begin
      result = (dbl >= wide_n) ? (WIDTH+1)'(dbl - wide_n) : (WIDTH+1)'(dbl);
    end else begin
      // acc < n keeps acc + n below 2^(WIDTH+1), so the halved sum fits
      result = acc[0] ? (WIDTH+1)'(sum >> 1) : (WIDTH+1)'({1'b0, acc} >> 1);
    end
  end

endmodule

// File: rtl/mont_convert.sv
// Bit-serial conversion into (x*R mod n) and out of (x*R^-1 mod n) the Montgomery domain.
module mont_convert
  import mont_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  mont_convert_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mont_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc_a;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] n_q;
  logic             mode_q;
  logic [WIDTH:0]   next_a;
  logic [WIDTH:0]   next_r;
  logic             bad_req;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] r_mod_q;
  logic             valid_q;
  logic             error_q;
  logic             busy_q;

  mont_bit_step #(.WIDTH(WIDTH)) u_step_a (
    .mode   (mode_q),
    .acc    (acc_a),
    .modulo (n_q),
    .result (next_a)
  );

  // R mod n is obtained by doubling 1 alongside the operand
  mont_bit_step #(.WIDTH(WIDTH)) u_step_r (
    .mode   (MODE_ENCODE),
    .acc    (acc_r),
    .modulo (n_q),
    .result (next_r)
  );

  always_comb begin
    bad_req = 1'b0;
    if (!bus.modulo_in[0] || (bus.modulo_in < WIDTH'(3)) || (bus.value_in >= bus.modulo_in))
      bad_req = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_a   <= '0;
      acc_r   <= '0;
      n_q     <= '0;
      mode_q  <= MODE_ENCODE;
      value_q <= '0;
      r_mod_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          error_q <= 1'b0;
          if (bus.valid_in) begin
            n_q    <= bus.modulo_in;
            mode_q <= bus.mode_in;
            acc_a  <= {1'b0, bus.value_in};
            acc_r  <= (WIDTH+1)'(1);
            cnt    <= '0;
            busy_q <= 1'b1;
            if (bad_req) begin
              state   <= DONE;
              value_q <= '0;
              r_mod_q <= '0;
              valid_q <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc_a <= next_a;
          acc_r <= next_r;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT)
            state <= FINAL;
        end
        FINAL: begin
          value_q <= (acc_a >= (WIDTH+1)'(n_q)) ? WIDTH'(acc_a - (WIDTH+1)'(n_q)) : WIDTH'(acc_a);
          r_mod_q <= (mode_q == MODE_ENCODE) ? WIDTH'(acc_r) : '0;
          valid_q <= 1'b1;
          error_q <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.value_out = value_q;
  assign bus.r_mod_out = r_mod_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_mont_convert.sv
// Directed and randomized checks of mont_convert against a modular-arithmetic reference model.
module tb_mont_convert;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mont_convert_if #(.WIDTH(W)) bus ();

  mont_convert #(.WIDTH(W)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint modinv(input longint a, input longint m);
    longint t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = m; nr = a % m;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

  function automatic longint model_enc(input longint x, input longint n);
    return (x * 65536) % n;
  endfunction

  function automatic longint model_dec(input longint x, input longint n);
    return (x * modinv(65536 % n, n)) % n;
  endfunction

  // Issue one request from IDLE; lat counts edges after the accepting edge until valid_out is seen
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] n, input logic m,
                        output logic [W-1:0] res, output logic [W-1:0] rm, output logic er, output int lat);
    logic got;
    @(negedge clk);
    bus.value_in = x; bus.modulo_in = n; bus.mode_in = m; bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.value_in  = W'($urandom);
    bus.modulo_in = W'($urandom);
    bus.mode_in   = 1'($urandom);
    got = 1'b0; lat = 0; res = '0; rm = '0; er = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.valid_out) begin
        got = 1'b1; res = bus.value_out; rm = bus.r_mod_out; er = bus.error_out;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy_out), 32'd0);
  endtask

  initial begin
    logic [W-1:0] res, rm, enc, n, x;
    logic er;
    int lat, pulses;
    logic [W-1:0] first_val;

    errors = 0; checks = 0;
    rst_n = 1'b0;
    bus.value_in = '0; bus.modulo_in = '0; bus.mode_in = 1'b0; bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(bus.value_out), 32'd0);
    check("rst_rmod", 32'(bus.r_mod_out), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_error", 32'(bus.error_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("enc8", 16'd8, 16'd61, 1'b0, res, rm, er, lat);
    check("enc8_value", 32'(res), 32'd54);
    check("enc8_rmod", 32'(rm), 32'd22);
    check("enc8_lat", 32'(lat), 32'(W + 1));
    check("enc8_err", 32'(er), 32'd0);

    run_op("dec54", 16'd54, 16'd61, 1'b1, res, rm, er, lat);
    check("dec54_value", 32'(res), 32'd8);
    check("dec54_rmod", 32'(rm), 32'd0);
    check("dec54_lat", 32'(lat), 32'(W + 1));

    run_op("dec22", 16'd22, 16'd61, 1'b1, res, rm, er, lat);
    check("dec22_value", 32'(res), 32'd1);
    check("dec22_rmod", 32'(rm), 32'd0);

    run_op("even60", 16'd8, 16'd60, 1'b0, res, rm, er, lat);
    check("even60_err", 32'(er), 32'd1);
    check("even60_value", 32'(res), 32'd0);
    check("even60_lat", 32'(lat), 32'd0);

    run_op("big69", 16'd69, 16'd61, 1'b0, res, rm, er, lat);
    check("big69_err", 32'(er), 32'd1);
    check("big69_value", 32'(res), 32'd0);
    check("big69_lat", 32'(lat), 32'd0);

    run_op("n1", 16'd0, 16'd1, 1'b1, res, rm, er, lat);
    check("n1_err", 32'(er), 32'd1);

    run_op("xeqn", 16'd61, 16'd61, 1'b1, res, rm, er, lat);
    check("xeqn_err", 32'(er), 32'd1);

    // Requests while busy and during the DONE cycle must both be dropped
    @(negedge clk);
    bus.value_in = 16'd8; bus.modulo_in = 16'd61; bus.mode_in = 1'b0; bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (4) @(negedge clk);
    bus.value_in = 16'd22; bus.mode_in = 1'b1; bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    pulses = 0; first_val = '0;
    for (int i = 0; i < 45; i++) begin
      if (bus.valid_out) begin
        if (pulses == 0) begin
          first_val = bus.value_out;
          bus.valid_in = 1'b1;
        end
        pulses++;
      end else begin
        bus.valid_in = 1'b0;
      end
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_value", 32'(first_val), 32'd54);
    check("ignore_busy", 32'(bus.busy_out), 32'd0);

    // Reset in the middle of an encode
    @(negedge clk);
    bus.value_in = 16'd8; bus.modulo_in = 16'd61; bus.mode_in = 1'b0; bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_before", 32'(bus.busy_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", 32'(bus.value_out), 32'd0);
    check("mid_rst_rmod", 32'(bus.r_mod_out), 32'd0);
    check("mid_rst_valid", 32'(bus.valid_out), 32'd0);
    check("mid_rst_error", 32'(bus.error_out), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'd54, 16'd61, 1'b1, res, rm, er, lat);
    check("post_rst_value", 32'(res), 32'd8);
    check("post_rst_lat", 32'(lat), 32'(W + 1));

    for (int t = 0; t < 8; t++) begin
      n = W'($urandom_range(1, 32767) * 2 + 1);
      x = W'($urandom_range(0, 32'(n) - 1));
      run_op("r_enc", x, n, 1'b0, enc, rm, er, lat);
      check("r_enc_value", 32'(enc), 32'(model_enc(longint'(x), longint'(n))));
      check("r_enc_rmod", 32'(rm), 32'(65536 % longint'(n)));
      check("r_enc_err", 32'(er), 32'd0);
      run_op("r_dec", enc, n, 1'b1, res, rm, er, lat);
      check("r_roundtrip", 32'(res), 32'(x));
      check("r_dec_model", 32'(res), 32'(model_dec(longint'(enc), longint'(n))));
      run_op("r_one", 16'd1, n, 1'b0, res, rm, er, lat);
      check("r_one_value", 32'(res), 32'(65536 % longint'(n)));
      check("r_one_rmod", 32'(rm), 32'(65536 % longint'(n)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
